// File: rtl/tug_match_ctrl.sv
// Tug-of-war match controller: rope position, round wins from button rising edges,
// per-player scores and match winner at a target score.
module tug_match_ctrl #(
   parameter int unsigned NUM_LIGHTS    = 9,
   parameter int unsigned WINS_TO_MATCH = 3,
   parameter int unsigned SCORE_W       = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  left,
   input  logic                  right,
   input  logic                  new_match,
   output logic [NUM_LIGHTS-1:0] lights,
   output logic [SCORE_W-1:0]    p1_score,
   output logic [SCORE_W-1:0]    p2_score,
   output logic                  round_win,
   output logic                  round_player,
   output logic                  match_over,
   output logic                  match_player
);

   localparam int unsigned          LP_CENTRE    = NUM_LIGHTS / 2;
   localparam logic [NUM_LIGHTS-1:0] LP_CENTRE_OH = NUM_LIGHTS'(1) << LP_CENTRE;
   localparam logic [SCORE_W-1:0]    LP_TARGET    = SCORE_W'(WINS_TO_MATCH);

   typedef enum logic {
      ST_PLAY = 1'b0,
      ST_OVER = 1'b1
   } state_t;

   state_t                  r_state;
   logic                    r_left_q;
   logic                    r_right_q;
   logic [NUM_LIGHTS-1:0]   r_lights;
   logic [SCORE_W-1:0]      r_p1_score;
   logic [SCORE_W-1:0]      r_p2_score;
   logic                    r_round_win;
   logic                    r_round_player;
   logic                    r_match_over;
   logic                    r_match_player;

   logic                    w_le;
   logic                    w_re;
   logic                    w_le_only;
   logic                    w_re_only;
   logic                    w_p1_win;
   logic                    w_p2_win;
   logic [SCORE_W-1:0]      w_p1_next;
   logic [SCORE_W-1:0]      w_p2_next;

   // Rising edges; simultaneous edges cancel each other
   assign w_le      = left  & ~r_left_q;
   assign w_re      = right & ~r_right_q;
   assign w_le_only = w_le & ~w_re;
   assign w_re_only = w_re & ~w_le;

   assign w_p1_win  = w_re_only & r_lights[0];
   assign w_p2_win  = w_le_only & r_lights[NUM_LIGHTS-1];
   assign w_p1_next = r_p1_score + SCORE_W'(1);
   assign w_p2_next = r_p2_score + SCORE_W'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= ST_PLAY;
         r_left_q       <= 1'b0;
         r_right_q      <= 1'b0;
         r_lights       <= LP_CENTRE_OH;
         r_p1_score     <= '0;
         r_p2_score     <= '0;
         r_round_win    <= 1'b0;
         r_round_player <= 1'b0;
         r_match_over   <= 1'b0;
         r_match_player <= 1'b0;
      end else begin
         r_left_q    <= left;
         r_right_q   <= right;
         r_round_win <= 1'b0;
         if (new_match) begin
            r_state      <= ST_PLAY;
            r_lights     <= LP_CENTRE_OH;
            r_p1_score   <= '0;
            r_p2_score   <= '0;
            r_match_over <= 1'b0;
         end else if (r_state == ST_PLAY) begin
            if (w_p1_win) begin
               r_round_win    <= 1'b1;
               r_round_player <= 1'b0;
               r_p1_score     <= w_p1_next;
               r_lights       <= LP_CENTRE_OH;
               if (w_p1_next == LP_TARGET) begin
                  r_state        <= ST_OVER;
                  r_match_over   <= 1'b1;
                  r_match_player <= 1'b0;
               end
            end else if (w_p2_win) begin
               r_round_win    <= 1'b1;
               r_round_player <= 1'b1;
               r_p2_score     <= w_p2_next;
               r_lights       <= LP_CENTRE_OH;
               if (w_p2_next == LP_TARGET) begin
                  r_state        <= ST_OVER;
                  r_match_over   <= 1'b1;
                  r_match_player <= 1'b1;
               end
            end else if (w_re_only) begin
               r_lights <= r_lights >> 1;
            end else if (w_le_only) begin
               r_lights <= r_lights << 1;
            end
         end
      end
   end

   assign lights       = r_lights;
   assign p1_score     = r_p1_score;
   assign p2_score     = r_p2_score;
   assign round_win    = r_round_win;
   assign round_player = r_round_player;
   assign match_over   = r_match_over;
   assign match_player = r_match_player;

endmodule

// File: tb/tb_tug_match_ctrl.sv
// Bench for tug_match_ctrl: directed vector table, corner-case sequences and
// randomized play against a position/score reference model.
module tb_tug_match_ctrl;

   localparam int unsigned N  = 9;
   localparam int unsigned WM = 3;
   localparam int unsigned SW = 3;
   localparam int unsigned C  = N / 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          left;
   logic          right;
   logic          new_match;
   logic [N-1:0]  lights;
   logic [SW-1:0] p1_score;
   logic [SW-1:0] p2_score;
   logic          round_win;
   logic          round_player;
   logic          match_over;
   logic          match_player;

   int checks   = 0;
   int failures = 0;

   tug_match_ctrl #(.NUM_LIGHTS(N), .WINS_TO_MATCH(WM), .SCORE_W(SW)) dut (
      .clk          (clk),
      .reset        (reset),
      .left         (left),
      .right        (right),
      .new_match    (new_match),
      .lights       (lights),
      .p1_score     (p1_score),
      .p2_score     (p2_score),
      .round_win    (round_win),
      .round_player (round_player),
      .match_over   (match_over),
      .match_player (match_player)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: rope as an integer position, scores as counts
   int m_pos, m_s1, m_s2, m_rw, m_rp, m_over, m_mp, m_pl, m_pr;

   task automatic model_reset();
      m_pos = C; m_s1 = 0; m_s2 = 0; m_rw = 0; m_rp = 0;
      m_over = 0; m_mp = 0; m_pl = 0; m_pr = 0;
   endtask

   task automatic model_win(input int p);
      m_rw  = 1;
      m_rp  = p;
      m_pos = C;
      if (p == 0) m_s1++; else m_s2++;
      if ((p == 0 ? m_s1 : m_s2) == WM) begin
         m_over = 1;
         m_mp   = p;
      end
   endtask

   task automatic model_step(input logic l, input logic r, input logic nm);
      int le, re;
      le = (l && !m_pl) ? 1 : 0;
      re = (r && !m_pr) ? 1 : 0;
      m_pl = l; m_pr = r;
      m_rw = 0;
      if (nm) begin
         m_pos = C; m_s1 = 0; m_s2 = 0; m_over = 0;
      end else if (!m_over) begin
         if (re && !le) begin
            if (m_pos == 0) model_win(0); else m_pos--;
         end else if (le && !re) begin
            if (m_pos == N - 1) model_win(1); else m_pos++;
         end
      end
   endtask

   task automatic step(input logic l, input logic r, input logic nm);
      @(negedge clk);
      left = l; right = r; new_match = nm;
      @(posedge clk);
      #1;
      model_step(l, r, nm);
   endtask

   task automatic press(input logic l, input logic r);
      step(l, r, 1'b0);
      step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_model(input string tag);
      logic [N-1:0] e_l;
      e_l = N'(1) << m_pos;
      chk({tag, "_lights"}, 32'(lights), 32'(e_l));
      chk({tag, "_onehot"}, 32'($countones(lights)), 32'd1);
      chk({tag, "_p1"}, 32'(p1_score), 32'(m_s1));
      chk({tag, "_p2"}, 32'(p2_score), 32'(m_s2));
      chk({tag, "_rw"}, 32'(round_win), 32'(m_rw));
      chk({tag, "_over"}, 32'(match_over), 32'(m_over));
      if (m_rw != 0)   chk({tag, "_rp"}, 32'(round_player), 32'(m_rp));
      if (m_over != 0) chk({tag, "_mp"}, 32'(match_player), 32'(m_mp));
   endtask

   task automatic do_reset();
      reset = 1'b0; left = 1'b0; right = 1'b0; new_match = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   typedef struct {
      logic         l;
      logic         r;
      logic         nm;
      logic [N-1:0] e_lights;
      int           e_p1;
      int           e_p2;
      logic         e_rw;
      logic         e_rp;
      logic         e_over;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic l, input logic r, input logic nm, input logic [N-1:0] el,
                      input int p1, input int p2, input logic rw, input logic rp, input logic ov);
      vec_t v;
      v.l = l; v.r = r; v.nm = nm; v.e_lights = el; v.e_p1 = p1; v.e_p2 = p2;
      v.e_rw = rw; v.e_rp = rp; v.e_over = ov;
      vecs.push_back(v);
   endtask

   initial begin
      // Right pulses to the edge, then a P1 round win
      add(0,1,0, 9'h008, 0,0, 0,0,0);
      add(0,0,0, 9'h008, 0,0, 0,0,0);
      add(0,1,0, 9'h004, 0,0, 0,0,0);
      add(0,0,0, 9'h004, 0,0, 0,0,0);
      add(0,1,0, 9'h002, 0,0, 0,0,0);
      add(0,0,0, 9'h002, 0,0, 0,0,0);
      add(0,1,0, 9'h001, 0,0, 0,0,0);
      add(0,0,0, 9'h001, 0,0, 0,0,0);
      add(0,1,0, 9'h010, 1,0, 1,0,0);
      add(0,0,0, 9'h010, 1,0, 0,0,0);
      // Held button moves once
      add(0,1,0, 9'h008, 1,0, 0,0,0);
      for (int i = 0; i < 6; i++) add(0,1,0, 9'h008, 1,0, 0,0,0);
      add(0,0,0, 9'h008, 1,0, 0,0,0);
      // Simultaneous edges ignored
      add(1,1,0, 9'h008, 1,0, 0,0,0);
      add(0,0,0, 9'h008, 1,0, 0,0,0);
      add(1,0,0, 9'h010, 1,0, 0,0,0);
      add(0,0,0, 9'h010, 1,0, 0,0,0);
      add(1,0,0, 9'h020, 1,0, 0,0,0);
      add(0,0,0, 9'h020, 1,0, 0,0,0);
      // new_match wins over a same-cycle edge
      add(0,1,1, 9'h010, 0,0, 0,0,0);
      add(0,0,0, 9'h010, 0,0, 0,0,0);

      do_reset();
      #1;
      chk("reset_lights", 32'(lights), 32'h010);
      chk("reset_p1", 32'(p1_score), 32'd0);
      chk("reset_p2", 32'(p2_score), 32'd0);
      chk("reset_rw", 32'(round_win), 32'd0);
      chk("reset_over", 32'(match_over), 32'd0);
      chk("reset_mp", 32'(match_player), 32'd0);

      foreach (vecs[i]) begin
         step(vecs[i].l, vecs[i].r, vecs[i].nm);
         chk($sformatf("vec%0d_lights", i), 32'(lights), 32'(vecs[i].e_lights));
         chk($sformatf("vec%0d_p1", i), 32'(p1_score), 32'(vecs[i].e_p1));
         chk($sformatf("vec%0d_p2", i), 32'(p2_score), 32'(vecs[i].e_p2));
         chk($sformatf("vec%0d_rw", i), 32'(round_win), 32'(vecs[i].e_rw));
         chk($sformatf("vec%0d_rp", i), 32'(round_player), 32'(vecs[i].e_rp));
         chk($sformatf("vec%0d_over", i), 32'(match_over), 32'(vecs[i].e_over));
      end

      // Leftmost then right: move away from the edge, no win
      for (int i = 0; i < 4; i++) press(1'b1, 1'b0);
      chk("leftmost", 32'(lights), 32'h100);
      step(1'b0, 1'b1, 1'b0);
      chk("edge_right_lights", 32'(lights), 32'h080);
      chk("edge_right_rw", 32'(round_win), 32'd0);
      chk("edge_right_p1", 32'(p1_score), 32'd0);
      step(1'b0, 1'b0, 1'b0);
      press(1'b0, 1'b1);
      press(1'b0, 1'b1);
      press(1'b0, 1'b1);
      chk("back_centre", 32'(lights), 32'h010);

      // P2 takes three rounds and the match
      for (int rnd = 0; rnd < 3; rnd++) begin
         for (int i = 0; i < 4; i++) press(1'b1, 1'b0);
         step(1'b1, 1'b0, 1'b0);
         chk("p2_win_rw", 32'(round_win), 32'd1);
         chk("p2_win_rp", 32'(round_player), 32'd1);
         chk("p2_win_score", 32'(p2_score), 32'(rnd + 1));
         chk("p2_win_lights", 32'(lights), 32'h010);
         chk("p2_win_over", 32'(match_over), (rnd == 2) ? 32'd1 : 32'd0);
         step(1'b0, 1'b0, 1'b0);
         chk("p2_win_pulse_end", 32'(round_win), 32'd0);
      end
      chk("match_player", 32'(match_player), 32'd1);
      step(1'b0, 1'b1, 1'b0);
      chk("over_right_rw", 32'(round_win), 32'd0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("over_left_rw", 32'(round_win), 32'd0);
      step(1'b0, 1'b0, 1'b0);
      chk("over_frozen_lights", 32'(lights), 32'h010);
      chk("over_frozen_p2", 32'(p2_score), 32'd3);
      chk("over_frozen_mp", 32'(match_player), 32'd1);
      chk("over_held", 32'(match_over), 32'd1);
      step(1'b1, 1'b0, 1'b1);
      chk("nm_p2", 32'(p2_score), 32'd0);
      chk("nm_over", 32'(match_over), 32'd0);
      chk("nm_lights", 32'(lights), 32'h010);
      step(1'b0, 1'b0, 1'b0);
      press(1'b1, 1'b0);
      chk("nm_play", 32'(lights), 32'h020);

      // Async reset mid-round with rope at bit 1
      press(1'b0, 1'b1);
      for (int i = 0; i < 5; i++) press(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) press(1'b0, 1'b1);
      chk("pre_reset_lights", 32'(lights), 32'h002);
      chk("pre_reset_p1", 32'(p1_score), 32'd1);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("async_lights", 32'(lights), 32'h010);
      chk("async_p1", 32'(p1_score), 32'd0);
      chk("async_over", 32'(match_over), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      model_reset();

      // Randomized play against the model
      for (int i = 0; i < 4000; i++) begin
         step(logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 2) == 0),
              logic'($urandom_range(0, 149) == 0));
         check_model("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
